// File: rtl/credit_pkg.sv
// credit_pkg: constants and helpers shared by the credit write/read controllers
// and the downstream credit FIFO.
//   DEF_DATA_WIDTH   - default payload width
//   DEF_INIT_CREDITS - default FIFO depth, i.e. credits held after reset
//   credit_width(n)  - bits needed to hold a credit count in the range 0..n
package credit_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_INIT_CREDITS = 16;

  // Count must reach n itself, hence n+1 states.
  function automatic int unsigned credit_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/credit_write_ctrl_if.sv
// credit_write_ctrl_if: producer handshake plus credit-FIFO write side.
//   in_data/in_valid/in_ready - producer word handshake
//   wdata/wvalid              - write strobe toward the credit FIFO
//   wcredit                   - credit return pulse from the FIFO
// master: the environment (producer + FIFO); slave: the controller.
interface credit_write_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wcredit;

  modport master (
    output in_data,
    output in_valid,
    output wcredit,
    input  in_ready,
    input  wdata,
    input  wvalid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  wcredit,
    output in_ready,
    output wdata,
    output wvalid
  );

endinterface

// File: rtl/credit_counter.sv
// credit_counter: credit pool shared by the write and read credit controllers.
//   clk, reset - clock, synchronous active-high reset
//   inc        - one credit returned this cycle
//   dec        - one credit consumed this cycle (caller only asserts it when count != 0)
//   count      - current credits, INIT_CREDITS after reset
//   overflow   - sticky: a credit came back while the pool was already full
module credit_counter
  import credit_pkg::*;
#(
  parameter int unsigned INIT_CREDITS = DEF_INIT_CREDITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  inc,
  input  logic                                  dec,
  output logic [credit_width(INIT_CREDITS)-1:0] count,
  output logic                                  overflow
);

  localparam int unsigned     CW  = credit_width(INIT_CREDITS);
  localparam logic [CW-1:0]   MAX = CW'(INIT_CREDITS);

  // next = count - dec + inc, saturating at MAX (flagged) and floored at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= MAX;
      overflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count == MAX) begin
            overflow <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        2'b01: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/credit_write_ctrl.sv
// credit_write_ctrl: buffers producer words and issues them to a credit-based
// FIFO write port, one word per available credit.
//   clk, reset    - clock, synchronous active-high reset
//   bus (slave)   - in_data/in_valid/in_ready producer side,
//                   wdata/wvalid write strobe, wcredit credit return
//   credits_avail - credits currently held
//   overflow_err  - sticky: more credits returned than INIT_CREDITS
// BUF_DEPTH must be a power of two and at least 2 so pointers wrap for free.
module credit_write_ctrl
  import credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned INIT_CREDITS = DEF_INIT_CREDITS,
  parameter int unsigned BUF_DEPTH    = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  credit_write_ctrl_if.slave                    bus,
  output logic [credit_width(INIT_CREDITS)-1:0] credits_avail,
  output logic                                  overflow_err
);

  localparam int unsigned   PW   = $clog2(BUF_DEPTH);
  localparam int unsigned   OW   = PW + 1;
  localparam logic [OW-1:0] FULL = OW'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         occ_next;
  logic                  push;
  logic                  pop;
  logic                  in_ready_q;
  logic                  wvalid_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Handshake and issue decisions use registered state only.
  assign push = bus.in_valid && in_ready_q;
  assign pop  = (occ != '0) && (credits_avail != '0);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + OW'(1);
      2'b01:   occ_next = occ - OW'(1);
      default: ;
    endcase
  end

  // Buffer pointers, occupancy and registered ready; ready is low for the
  // reset cycle and tracks occupancy afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ        <= occ_next;
      in_ready_q <= (occ_next < FULL);
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers/occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Issue register: one strobe per pop, data holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      wvalid_q <= pop;
      if (pop) begin
        wdata_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wvalid   = wvalid_q;
  assign bus.wdata    = wdata_q;

  credit_counter #(
    .INIT_CREDITS (INIT_CREDITS)
  ) u_credit_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (bus.wcredit),
    .dec      (pop),
    .count    (credits_avail),
    .overflow (overflow_err)
  );

endmodule

// File: tb/tb_credit_write_ctrl.sv
// tb_credit_write_ctrl: directed stimulus with a scoreboard queue of accepted
// words; a monitor pops and compares on every wvalid strobe.
module tb_credit_write_ctrl;
  import credit_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned IC   = 16;
  localparam int unsigned CWID = credit_width(IC);

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [CWID-1:0] credits_avail;
  logic            overflow_err;

  int checks   = 0;
  int errors   = 0;
  int strobes  = 0;
  int returned = 0;
  logic [DW-1:0] exp_q[$];

  credit_write_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  credit_write_ctrl #(
    .DATA_WIDTH   (DW),
    .INIT_CREDITS (IC),
    .BUF_DEPTH    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .credits_avail (credits_avail),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Called right after a falling edge: offer a word; it is accepted on the
  // next rising edge only if in_ready is high now.
  task automatic drive_word(input logic [DW-1:0] d, input string name);
    chk(name, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (bus.in_ready) exp_q.push_back(d);
  endtask

  task automatic do_reset(input logic credit_during_reset);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.wcredit  = credit_during_reset;
    @(negedge clk);
    reset       = 1'b0;
    bus.wcredit = 1'b0;
    chk("rst_in_ready",  int'(bus.in_ready),    0);
    chk("rst_wvalid",    int'(bus.wvalid),      0);
    chk("rst_wdata",     int'(bus.wdata),       0);
    chk("rst_credits",   int'(credits_avail),   int'(IC));
    chk("rst_overflow",  int'(overflow_err),    0);
    @(negedge clk);
    chk("rst_in_ready_after", int'(bus.in_ready), 1);
  endtask

  // Monitor: compares every strobe against the scoreboard and tracks the
  // outstanding-credit bound; a reset edge flushes expectations.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        strobes  = 0;
        returned = 0;
      end else if (bus.wcredit) begin
        returned++;
      end
      if (bus.wvalid === 1'b1) begin
        strobes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wvalid: got wdata %0d with no word pending (t=%0t)",
                   bus.wdata, $time);
        end else begin
          chk("wdata_order", int'(bus.wdata), int'(exp_q.pop_front()));
        end
        chk("credit_bound", (strobes - returned <= int'(IC)) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wcredit  = 1'b0;
    do_reset(1'b0);

    // 17 back-to-back words, no credit returns: 16 issue, the 17th waits.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_word(DW'(16 + i), "a_in_ready");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("a_strobe_count", strobes, 16);
    chk("a_last_wvalid",  int'(bus.wvalid), 1);
    chk("a_last_wdata",   int'(bus.wdata), 'h1f);
    chk("a_credits_zero", int'(credits_avail), 0);
    repeat (3) begin
      @(negedge clk);
      chk("a_held_wvalid",   int'(bus.wvalid), 0);
      chk("a_held_credits",  int'(credits_avail), 0);
      chk("a_held_in_ready", int'(bus.in_ready), 1);
    end

    // One credit at count 0 releases the buffered word.
    @(negedge clk);
    bus.wcredit = 1'b1;
    @(negedge clk);
    bus.wcredit = 1'b0;
    chk("b_credits_one", int'(credits_avail), 1);
    @(negedge clk);
    chk("b_wvalid",       int'(bus.wvalid), 1);
    chk("b_wdata",        int'(bus.wdata), 'h20);
    chk("b_credits_zero", int'(credits_avail), 0);

    // Prime 3 credits, then stream 100 words with a credit back every cycle.
    repeat (3) begin
      @(negedge clk);
      bus.wcredit = 1'b1;
    end
    @(negedge clk);
    bus.wcredit = 1'b0;
    chk("c_credits_primed", int'(credits_avail), 3);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k >= 1) chk("c_credits_const", int'(credits_avail), 3);
      bus.wcredit = (k >= 1);
      if (k < 100) drive_word(DW'(k + 100), "c_in_ready");
      else         bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.wcredit = 1'b0;
    chk("c_credits_end", int'(credits_avail), 3);
    chk("c_drained",     exp_q.size(), 0);

    // Credit returned into a full pool: sticky overflow, count holds.
    do_reset(1'b0);
    @(negedge clk);
    bus.wcredit = 1'b1;
    @(negedge clk);
    bus.wcredit = 1'b0;
    chk("d_overflow",     int'(overflow_err), 1);
    chk("d_credits_hold", int'(credits_avail), int'(IC));
    repeat (3) begin
      @(negedge clk);
      chk("d_overflow_sticky", int'(overflow_err), 1);
      chk("d_credits_sticky",  int'(credits_avail), int'(IC));
    end

    // Spend 11 credits to reach 5, then measure single-word latency.
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_word(DW'(80 + i), "e_in_ready");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("e_credits_five", int'(credits_avail), 5);
    chk("e_idle_wvalid",  int'(bus.wvalid), 0);
    chk("e_drained",      exp_q.size(), 0);
    @(negedge clk);
    drive_word(8'hA5, "e_single_in_ready");
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("e_t1_wvalid",  int'(bus.wvalid), 0);
    chk("e_t1_credits", int'(credits_avail), 5);
    @(negedge clk);
    chk("e_t2_wvalid",  int'(bus.wvalid), 1);
    chk("e_t2_wdata",   int'(bus.wdata), 'hA5);
    chk("e_t2_credits", int'(credits_avail), 4);

    // Exhaust credits and fill the buffer, then reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_word(DW'(192 + i), "f_in_ready");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("f_full_in_ready", int'(bus.in_ready), 0);
    chk("f_full_credits",  int'(credits_avail), 0);
    chk("f_full_pending",  exp_q.size(), 2);
    @(negedge clk);
    chk("f_stalled_wvalid", int'(bus.wvalid), 0);
    do_reset(1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("f_no_stale_wvalid", int'(bus.wvalid), 0);
      chk("f_post_credits",    int'(credits_avail), int'(IC));
    end
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
